cnn16_mem_arbiter: RTL and testbench

- Single-port RAM arbiter between the external program loader (host) and the CNN_16 CPU core.
- Replaces the combinational sel_in mux in front of cnn16_ram with a sequenced, registered access controller.
- Generates a proper per-requester grant and read-valid handshake. Read-valid drives the CPU's mem_ready.
- Host has priority, with a bounded anti-starvation slot for the CPU. While sel_in=1 (load mode), the CPU is locked out.

---
 rtl/cnn16_pkg.sv | 8 +
 rtl/cnn16_rr_pick.sv | 18 +
 rtl/cnn16_mem_arbiter.sv | 96 +++++++++
 tb/tb_cnn16_mem_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cnn16_pkg.sv
// cnn16_pkg: shared types and defaults for the CNN_16 memory arbiter.
package cnn16_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;
  localparam logic OWNER_HOST = 1'b0;
  localparam logic OWNER_CPU  = 1'b1;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 16;
endpackage

// File: rtl/cnn16_rr_pick.sv
// cnn16_rr_pick: host-priority winner selection with a bounded CPU slot.
module cnn16_rr_pick #(
  parameter int HOST_BURST = 4
) (
  input  logic       host_req,
  input  logic       cpu_req,
  input  logic       sel_in,
  input  logic [3:0] streak,
  output logic       pick_host,
  output logic       pick_cpu
);
  logic cpu_ok;
  always_comb begin
    cpu_ok    = cpu_req && !sel_in;
    pick_cpu  = cpu_ok && (!host_req || streak == 4'(HOST_BURST));
    pick_host = host_req && !pick_cpu;
  end
endmodule

// File: rtl/cnn16_mem_arbiter.sv
// cnn16_mem_arbiter: sequenced single-port RAM access controller shared by
// the host program loader and the CNN_16 core.
module cnn16_mem_arbiter
  import cnn16_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LAT     = 1,
  parameter int HOST_BURST = 4
) (
  input  logic              clkn,
  input  logic              rstn,
  input  logic              sel_in,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_adr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_ready,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              owner
);
  state_t     state, state_nxt;
  logic       pick_host, pick_cpu, idle, cap, lat_we, own;
  logic [2:0] cnt;
  logic [3:0] streak;

  cnn16_rr_pick #(.HOST_BURST(HOST_BURST)) u_pick (
    .host_req (host_req),
    .cpu_req  (cpu_req),
    .sel_in   (sel_in),
    .streak   (streak),
    .pick_host(pick_host),
    .pick_cpu (pick_cpu)
  );

  always_ff @(posedge clkn or negedge rstn)
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;

  always_comb
    state_nxt = (state == IDLE)   ? ((pick_host || pick_cpu) ? ACCESS : IDLE) :
                (state == ACCESS) ? (lat_we ? IDLE : WAIT) :
                (cnt == 3'd1)     ? IDLE : WAIT;

  always_comb begin
    idle      = state == IDLE;
    busy      = !idle;
    owner     = own;
    mem_write = state == ACCESS && lat_we;
    host_gnt  = state == ACCESS && own == OWNER_HOST;
    cpu_gnt   = state == ACCESS && own == OWNER_CPU;
    cap       = state == WAIT && cnt == 3'd1;
  end

  // The request latch doubles as the RAM address/data drivers, so they hold between accesses.
  always_ff @(posedge clkn or negedge rstn)
    if (!rstn) begin
      lat_we      <= 1'b0;
      own         <= OWNER_HOST;
      mem_adr     <= '0;
      mem_din     <= '0;
      cnt         <= 3'd0;
      streak      <= 4'd0;
      host_rdata  <= '0;
      cpu_rdata   <= '0;
      host_rvalid <= 1'b0;
      mem_ready   <= 1'b0;
    end else begin
      if (idle && (pick_host || pick_cpu)) begin
        lat_we  <= pick_cpu ? cpu_we : host_we;
        mem_adr <= pick_cpu ? cpu_adr : host_adr;
        mem_din <= pick_cpu ? cpu_wdata : host_wdata;
        own     <= pick_cpu ? OWNER_CPU : OWNER_HOST;
      end
      cnt         <= (state == ACCESS) ? 3'(RD_LAT) : (state == WAIT) ? cnt - 3'd1 : cnt;
      host_rvalid <= cap && own == OWNER_HOST;
      mem_ready   <= cap && own == OWNER_CPU;
      if (cap && own == OWNER_HOST) host_rdata <= mem_dout;
      if (cap && own == OWNER_CPU)  cpu_rdata  <= mem_dout;
      streak <= (sel_in || !cpu_req || (idle && pick_cpu)) ? 4'd0 :
                (idle && pick_host && streak != 4'(HOST_BURST)) ? streak + 4'd1 : streak;
    end
endmodule

// File: tb/tb_cnn16_mem_arbiter.sv
// tb_cnn16_mem_arbiter: directed test of the arbiter with RD_LAT=1 (u_dut) and
// RD_LAT=3 (u_dut3) instances sharing one stimulus stream.
module tb_cnn16_mem_arbiter;
  logic        clkn = 1'b0, rstn = 1'b0, sel_in = 1'b0;
  logic        host_req = 1'b0, host_we = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [11:0] host_adr = '0, cpu_adr = '0;
  logic [15:0] host_wdata = '0, cpu_wdata = '0;
  logic        host_gnt, host_rvalid, cpu_gnt, mem_ready, mem_write, busy, owner;
  logic [15:0] host_rdata, cpu_rdata, mem_din, mem_dout;
  logic [11:0] mem_adr;
  logic        host_gnt3, host_rvalid3, cpu_gnt3, mem_ready3, mem_write3, busy3, owner3;
  logic [15:0] host_rdata3, cpu_rdata3, mem_din3, mem_dout3;
  logic [11:0] mem_adr3;
  logic [15:0] ram1 [4096];
  logic [15:0] ram3 [4096];
  logic [15:0] p3 [3];
  int n_chk = 0, n_fail = 0;

  always #5 clkn = ~clkn;

  cnn16_mem_arbiter #(.RD_LAT(1), .HOST_BURST(4)) u_dut (
    .clkn(clkn), .rstn(rstn), .sel_in(sel_in),
    .host_req(host_req), .host_we(host_we), .host_adr(host_adr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .mem_ready(mem_ready),
    .mem_write(mem_write), .mem_adr(mem_adr), .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy), .owner(owner)
  );

  cnn16_mem_arbiter #(.RD_LAT(3), .HOST_BURST(4)) u_dut3 (
    .clkn(clkn), .rstn(rstn), .sel_in(sel_in),
    .host_req(host_req), .host_we(host_we), .host_adr(host_adr), .host_wdata(host_wdata),
    .host_gnt(host_gnt3), .host_rdata(host_rdata3), .host_rvalid(host_rvalid3),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt3), .cpu_rdata(cpu_rdata3), .mem_ready(mem_ready3),
    .mem_write(mem_write3), .mem_adr(mem_adr3), .mem_din(mem_din3), .mem_dout(mem_dout3),
    .busy(busy3), .owner(owner3)
  );

  always @(posedge clkn) begin
    if (mem_write) ram1[mem_adr] <= mem_din;
    mem_dout <= ram1[mem_adr];
    if (mem_write3) ram3[mem_adr3] <= mem_din3;
    p3[0] <= ram3[mem_adr3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_dout3 = p3[2];

  task automatic tick;
    @(posedge clkn);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       any_gnt, any_wr;
    logic [9:0] seq;
    int         ngr, lim;
    // reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_adr", mem_adr, 0);
    chk("rst_gnt", {host_gnt, cpu_gnt}, 0);
    chk("rst_rdata", {host_rdata, cpu_rdata}, 0);
    rstn = 1'b1;
    tick;
    // 1: host write 0x1234 -> 0x005 in load mode
    sel_in = 1; host_req = 1; host_we = 1; host_adr = 12'h005; host_wdata = 16'h1234;
    tick;
    chk("t1_host_gnt", host_gnt, 1);
    chk("t1_mem_write", mem_write, 1);
    chk("t1_mem_adr", mem_adr, 12'h005);
    chk("t1_mem_din", mem_din, 16'h1234);
    chk("t1_owner", owner, 0);
    host_req = 0;
    tick;
    chk("t1_write_1cyc", mem_write, 0);
    chk("t1_busy_low", busy, 0);
    chk("t1_adr_hold", mem_adr, 12'h005);
    // 2: CPU read of 0x005, sel_in rises mid-transaction
    sel_in = 0; cpu_req = 1; cpu_we = 0; cpu_adr = 12'h005;
    tick;
    chk("t2_cpu_gnt", cpu_gnt, 1);
    chk("t2_owner", owner, 1);
    chk("t2_no_write", mem_write, 0);
    cpu_req = 0; sel_in = 1;
    tick;
    chk("t2_ready_early", mem_ready, 0);
    tick;
    chk("t2_mem_ready", mem_ready, 1);
    chk("t2_cpu_rdata", cpu_rdata, 16'h1234);
    chk("t2_host_rvalid", host_rvalid, 0);
    tick;
    chk("t2_ready_pulse", mem_ready, 0);
    // 3: CPU locked out in load mode
    cpu_req = 1; cpu_we = 1; cpu_adr = 12'h010; cpu_wdata = 16'hBEEF;
    any_gnt = 0; any_wr = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      any_gnt |= cpu_gnt;
      any_wr |= mem_write;
    end
    chk("t3_no_cpu_gnt", any_gnt, 0);
    chk("t3_no_ram_write", any_wr, 0);
    sel_in = 0;
    tick;
    chk("t3_cpu_gnt_after_sel", cpu_gnt, 1);
    chk("t3_cpu_wdata", mem_din, 16'hBEEF);
    cpu_req = 0;
    tick;
    // 4: grant order with both requesters held
    host_req = 1; host_we = 1; host_adr = 12'h020; host_wdata = 16'h0001;
    cpu_req = 1; cpu_we = 1; cpu_adr = 12'h021; cpu_wdata = 16'h0002;
    seq = '0; ngr = 0; lim = 0;
    while (ngr < 10 && lim < 60) begin
      tick;
      lim++;
      if (host_gnt) begin seq[ngr] = 1'b0; ngr++; end
      else if (cpu_gnt) begin seq[ngr] = 1'b1; ngr++; end
    end
    host_req = 0; cpu_req = 0;
    chk("t4_grant_count", ngr, 10);
    chk("t4_grant_order", seq, 10'b1000010000);
    tick;
    tick;
    // 5: reset asserted during the ACCESS cycle of a host write
    host_req = 1; host_we = 1; host_adr = 12'h0FF; host_wdata = 16'hA5A5;
    tick;
    chk("t5_in_access", mem_write, 1);
    #2 rstn = 0;
    #1;
    chk("t5_rst_mem_write", mem_write, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_gnt", host_gnt, 0);
    chk("t5_rst_mem_bus", {mem_adr, mem_din}, 0);
    chk("t5_rst_cpu_rdata", cpu_rdata, 0);
    host_req = 0;
    tick;
    chk("t5_hold_write", mem_write, 0);
    rstn = 1;
    tick;
    chk("t5_idle", busy, 0);
    chk("t5_no_write", mem_write, 0);
    // 6: RD_LAT=3 instance: write then read 0xFFF with a pending CPU read
    host_req = 1; host_we = 1; host_adr = 12'hFFF; host_wdata = 16'hFFFF;
    tick;
    chk("t6_wr_gnt", host_gnt3, 1);
    chk("t6_wr_bus", {mem_adr3, mem_din3}, {12'hFFF, 16'hFFFF});
    host_req = 0;
    tick;
    host_req = 1; host_we = 0; cpu_req = 1; cpu_we = 0; cpu_adr = 12'h005;
    tick;
    chk("t6_rd_gnt", host_gnt3, 1);
    host_req = 0;
    tick;
    chk("t6_rvalid_p2", host_rvalid3, 0);
    tick;
    tick;
    chk("t6_rvalid_p4", host_rvalid3, 0);
    chk("t6_cpu_blocked", cpu_gnt3, 0);
    tick;
    chk("t6_host_rvalid", host_rvalid3, 1);
    chk("t6_host_rdata", host_rdata3, 16'hFFFF);
    chk("t6_no_mem_ready", mem_ready3, 0);
    tick;
    chk("t6_cpu_gnt", cpu_gnt3, 1);
    chk("t6_rvalid_pulse", host_rvalid3, 0);
    cpu_req = 0;
    tick;
    tick;
    tick;
    chk("t6_ready_early", mem_ready3, 0);
    tick;
    chk("t6_mem_ready", mem_ready3, 1);
    chk("t6_cpu_rdata", cpu_rdata3, 16'h1234);
    chk("t6_host_rdata_hold", host_rdata3, 16'hFFFF);
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
